led_display_arbiter: RTL and testbench



---
 rtl/led_display_arbiter_pkg.sv | 47 ++++
 rtl/led_display_arbiter_ms_tick_gen.sv | 27 ++
 rtl/led_display_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_led_display_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_arbiter_pkg.sv
// Shared source/state encodings and counter width helper
// for the LED display arbiter and its tick generator.
package led_display_arbiter_pkg;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_TEMP = 2'd1;
  localparam logic [1:0] SRC_KEY  = 2'd2;
  localparam logic [1:0] SRC_MSG  = 2'd3;

  typedef enum logic [2:0] {
    ST_BLANK,
    ST_GAP,
    ST_TEMP,
    ST_KEY,
    ST_MSG
  } state_e;

  // Width of a counter that spans 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_w(int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

  function automatic logic [1:0] src_of(state_e s);
    logic [1:0] r;
    case (s)
      ST_TEMP: r = SRC_TEMP;
      ST_KEY:  r = SRC_KEY;
      ST_MSG:  r = SRC_MSG;
      default: r = SRC_NONE;
    endcase
    return r;
  endfunction

  function automatic state_e state_for(logic [1:0] src);
    state_e r;
    case (src)
      SRC_TEMP: r = ST_TEMP;
      SRC_KEY:  r = ST_KEY;
      SRC_MSG:  r = ST_MSG;
      default:  r = ST_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_display_arbiter_ms_tick_gen.sv
// Free-running prescaler; tick_o pulses one cycle every DIV clocks.
// Ports: clk, rst_n (async, active-low), tick_o.
module ms_tick_gen
  import led_display_arbiter_pkg::*;
#(
  parameter int unsigned DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Priority arbiter for the 8-digit display: msg > key > temp,
// blanking gap on source change, timed/blinking messages.
// Ports: temp_*, key_*, msg_* requesters in; disp_* driver out.
module led_display_arbiter
  import led_display_arbiter_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned MSG_MS        = 2000,
  parameter int unsigned GAP_MS        = 2,
  parameter int unsigned BLINK_MS      = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        temp_valid,
  input  logic [31:0] temp_data,
  input  logic        key_active,
  input  logic [31:0] key_data,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  input  logic        msg_blink,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic        disp_en,
  output logic [31:0] disp_data,
  output logic [1:0]  disp_src
);

  localparam int unsigned MW = cnt_w(MSG_MS);
  localparam int unsigned GW = cnt_w(GAP_MS);
  localparam int unsigned BW = cnt_w(BLINK_MS);
  localparam logic [MW-1:0] M_LAST = MW'(MSG_MS - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_MS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_MS - 1);

  logic tick;

  ms_tick_gen #(
    .DIV (CLK_FREQUENCY / 1000)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  logic [31:0]   temp_q;
  logic          have_q;
  logic [31:0]   msg_q;
  logic          mblink_q;
  logic          busy_q;
  logic          ack_q;
  logic [MW-1:0] mms_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q   <= '0;
      have_q   <= 1'b0;
      msg_q    <= '0;
      mblink_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      mms_q    <= '0;
    end else begin
      if (temp_valid) begin
        temp_q <= temp_data;
        have_q <= 1'b1;
      end
      ack_q <= 1'b0;
      if (!busy_q) begin
        if (msg_req) begin
          msg_q    <= msg_data;
          mblink_q <= msg_blink;
          busy_q   <= 1'b1;
          ack_q    <= 1'b1;
          mms_q    <= '0;
        end
      end else if (tick) begin
        if (mms_q == M_LAST) busy_q <= 1'b0;
        else                 mms_q  <= mms_q + MW'(1);
      end
    end
  end

  logic [1:0] wanted;

  always_comb begin
    wanted = SRC_NONE;
    if (busy_q)          wanted = SRC_MSG;
    else if (key_active) wanted = SRC_KEY;
    else if (have_q)     wanted = SRC_TEMP;
  end

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          on_q, on_d;
  logic          en_d;
  logic [31:0]   data_d;
  logic [1:0]    src_d;
  logic          en_q;
  logic [31:0]   data_q;
  logic [1:0]    src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      gap_q   <= '0;
      blk_q   <= '0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      blk_q   <= blk_d;
      on_q    <= on_d;
      en_q    <= en_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  // The gap retargets to whatever is wanted when it expires.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_GAP: begin
        if (tick) begin
          if (gap_q == G_LAST) begin
            gap_d   = '0;
            state_d = state_for(wanted);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: begin
        if (wanted != src_of(state_q)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
    endcase
  end

  // Blink phase restarts "on" at each MSG entry.
  always_comb begin
    blk_d = blk_q;
    on_d  = on_q;
    if (state_d == ST_MSG && state_q != ST_MSG) begin
      blk_d = '0;
      on_d  = 1'b1;
    end else if (state_q == ST_MSG && tick) begin
      if (blk_q == B_LAST) begin
        blk_d = '0;
        on_d  = !on_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end
  end

  always_comb begin
    en_d   = 1'b0;
    data_d = '0;
    src_d  = SRC_NONE;
    unique case (state_d)
      ST_TEMP: begin
        en_d   = 1'b1;
        data_d = temp_valid ? temp_data : temp_q;
        src_d  = SRC_TEMP;
      end
      ST_KEY: begin
        en_d   = 1'b1;
        data_d = key_data;
        src_d  = SRC_KEY;
      end
      ST_MSG: begin
        en_d   = !mblink_q || on_d;
        data_d = msg_q;
        src_d  = SRC_MSG;
      end
      default: ;
    endcase
  end

  assign msg_ack   = ack_q;
  assign msg_busy  = busy_q;
  assign disp_en   = en_q;
  assign disp_data = data_q;
  assign disp_src  = src_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench: tick/deadline model plus directed
// literal checks for led_display_arbiter.
module tb_led_display_arbiter;

  localparam int unsigned CLKF  = 10_000;
  localparam int unsigned DIV   = CLKF / 1000;
  localparam int unsigned MSGMS = 5;
  localparam int unsigned GAPMS = 2;
  localparam int unsigned BLKMS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        temp_valid = 1'b0;
  logic [31:0] temp_data = '0;
  logic        key_active = 1'b0;
  logic [31:0] key_data = '0;
  logic        msg_req = 1'b0;
  logic [31:0] msg_data = '0;
  logic        msg_blink = 1'b0;
  logic        msg_ack;
  logic        msg_busy;
  logic        disp_en;
  logic [31:0] disp_data;
  logic [1:0]  disp_src;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  led_display_arbiter #(
    .CLK_FREQUENCY (CLKF),
    .MSG_MS        (MSGMS),
    .GAP_MS        (GAPMS),
    .BLINK_MS      (BLKMS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_valid (temp_valid),
    .temp_data  (temp_data),
    .key_active (key_active),
    .key_data   (key_data),
    .msg_req    (msg_req),
    .msg_data   (msg_data),
    .msg_blink  (msg_blink),
    .msg_ack    (msg_ack),
    .msg_busy   (msg_busy),
    .disp_en    (disp_en),
    .disp_data  (disp_data),
    .disp_src   (disp_src)
  );

  always #5 clk = ~clk;

  // Model: absolute tick count with deadlines instead of counters.
  int          phase = 0;
  int          ntick = 0;
  bit          m_busy = 0;
  bit          m_have = 0;
  bit          m_ack = 0;
  bit          m_bmode = 0;
  bit          m_ingap = 0;
  int          m_shown = 0;
  int          gap_end = 0;
  int          msg_end = 0;
  int          msg_entry = 0;
  logic [31:0] m_temp = '0;
  logic [31:0] m_msg = '0;
  bit          e_en = 0;
  logic [31:0] e_data = '0;
  int          e_src = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; ntick = 0;
      m_busy = 0; m_have = 0; m_ack = 0; m_bmode = 0;
      m_ingap = 0; m_shown = 0;
      m_temp = '0; m_msg = '0;
      e_en = 0; e_data = '0; e_src = 0;
    end else begin
      bit tick;
      int wanted;
      tick = (phase == DIV - 1);
      phase = tick ? 0 : phase + 1;
      if (tick) ntick++;
      wanted = m_busy ? 3 : key_active ? 2 : m_have ? 1 : 0;
      m_ack = 0;
      if (!m_busy) begin
        if (msg_req) begin
          m_busy = 1; m_ack = 1;
          m_msg = msg_data; m_bmode = msg_blink;
          msg_end = ntick + MSGMS;
        end
      end else if (tick && ntick == msg_end) begin
        m_busy = 0;
      end
      if (temp_valid) begin
        m_temp = temp_data; m_have = 1;
      end
      if (m_ingap) begin
        if (tick && ntick == gap_end) begin
          m_ingap = 0;
          m_shown = wanted;
          if (wanted == 3) msg_entry = ntick;
        end
      end else if (wanted != m_shown) begin
        m_ingap = 1;
        gap_end = ntick + GAPMS;
      end
      e_en = 0; e_data = '0; e_src = 0;
      if (!m_ingap) begin
        case (m_shown)
          1: begin e_en = 1; e_data = m_temp; e_src = 1; end
          2: begin e_en = 1; e_data = key_data; e_src = 2; end
          3: begin
            e_src = 3; e_data = m_msg;
            e_en = !m_bmode ||
                   (((ntick - msg_entry) / BLKMS) % 2 == 0);
          end
          default: ;
        endcase
      end
    end
  end

  int prints = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (disp_en !== e_en || disp_data !== e_data ||
          disp_src !== 2'(e_src) || msg_ack !== m_ack ||
          msg_busy !== m_busy) begin
        errors++;
        if (prints < 20) begin
          prints++;
          $display("FAIL model t=%0t got en=%b d=%h s=%0d ack=%b bsy=%b want en=%b d=%h s=%0d ack=%b bsy=%b",
                   $time, disp_en, disp_data, disp_src, msg_ack, msg_busy,
                   e_en, e_data, e_src, m_ack, m_busy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (msg_busy && n < 200) begin
      step(1);
      n++;
    end
    chk(name, {31'd0, msg_busy}, 32'd0);
  endtask

  initial begin
    int n;
    bit saw_on;
    bit saw_off;
    step(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1);
    chk("rst_en", {31'd0, disp_en}, 32'd0);
    chk("rst_src", {30'd0, disp_src}, 32'd0);
    chk("rst_busy", {31'd0, msg_busy}, 32'd0);
    step(50);
    chk("idle_src", {30'd0, disp_src}, 32'd0);
    chk("idle_en", {31'd0, disp_en}, 32'd0);

    temp_data = 32'h0002_5375;
    temp_valid = 1'b1;
    step(1);
    temp_valid = 1'b0;
    chk("temp_gap_en", {31'd0, disp_en}, 32'd0);
    step(40);
    chk("temp_src", {30'd0, disp_src}, 32'd1);
    chk("temp_en", {31'd0, disp_en}, 32'd1);
    chk("temp_data", disp_data, 32'h0002_5375);

    key_data = 32'h1234_5678;
    key_active = 1'b1;
    step(2);
    chk("key_gap_en", {31'd0, disp_en}, 32'd0);
    step(40);
    chk("key_src", {30'd0, disp_src}, 32'd2);
    chk("key_data", disp_data, 32'h1234_5678);
    key_data = 32'hCAFE_F00D;
    step(1);
    chk("key_track", disp_data, 32'hCAFE_F00D);
    key_active = 1'b0;
    step(40);
    chk("back_temp", disp_data, 32'h0002_5375);

    msg_data = 32'hEEEE_0001;
    msg_blink = 1'b1;
    msg_req = 1'b1;
    step(1);
    msg_req = 1'b0;
    chk("ack_hi", {31'd0, msg_ack}, 32'd1);
    chk("busy_hi", {31'd0, msg_busy}, 32'd1);
    step(1);
    chk("ack_lo", {31'd0, msg_ack}, 32'd0);
    step(20);
    msg_data = 32'h0BAD_0BAD;
    msg_req = 1'b1;
    step(1);
    msg_req = 1'b0;
    chk("ack_busy", {31'd0, msg_ack}, 32'd0);
    n = 0; saw_on = 0; saw_off = 0;
    while (msg_busy && n < 200) begin
      if (disp_src == 2'd3 && disp_en) saw_on = 1;
      if (disp_src == 2'd3 && !disp_en) saw_off = 1;
      step(1);
      n++;
    end
    n = n + 22;
    chk("busy_dur", {31'd0, n >= 41 && n <= 50}, 32'd1);
    chk("blink", {30'd0, saw_on, saw_off}, 32'd3);
    step(40);
    chk("msg_done_src", {30'd0, disp_src}, 32'd1);

    key_data = 32'h0000_7777;
    key_active = 1'b1;
    temp_data = 32'h0000_0031;
    temp_valid = 1'b1;
    msg_data = 32'hA5A5_0002;
    msg_blink = 1'b0;
    msg_req = 1'b1;
    step(1);
    temp_valid = 1'b0;
    msg_req = 1'b0;
    chk("sim_ack", {31'd0, msg_ack}, 32'd1);
    step(30);
    chk("msg_solid", {31'd0, disp_en}, 32'd1);
    chk("msg_data", disp_data, 32'hA5A5_0002);
    wait_idle("msg2_end", n);
    step(40);
    chk("exp_key", {30'd0, disp_src}, 32'd2);
    key_active = 1'b0;
    step(40);
    chk("new_temp", disp_data, 32'h0000_0031);

    msg_blink = 1'b1;
    msg_req = 1'b1;
    step(1);
    msg_req = 1'b0;
    step(25);
    rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, disp_en}, 32'd0);
    chk("arst_src", {30'd0, disp_src}, 32'd0);
    chk("arst_data", disp_data, 32'd0);
    chk("arst_busy", {30'd0, msg_busy, msg_ack}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(50);
    chk("no_temp", {30'd0, disp_src}, 32'd0);
    key_active = 1'b1;
    step(5);
    key_active = 1'b0;
    step(40);
    chk("key_drop_blank", {30'd0, disp_src}, 32'd0);
    temp_data = 32'h0000_0042;
    temp_valid = 1'b1;
    step(1);
    temp_valid = 1'b0;
    step(40);
    chk("temp_again", disp_data, 32'h0000_0042);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
